// File: rtl/wb_ram_bridge_if.sv
// Wishbone classic bus bundle between a bus master and wb_ram_bridge.
// Member names are given from the slave's point of view.
interface wb_ram_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_ram_bridge.sv
// Wishbone classic slave in front of a one-cycle-latency, read-first synchronous RAM.
// Define WB_RAM_BYTE_SEL_EN to turn partial-word stores into read-modify-write.
module wb_ram_bridge #(
    parameter logic [31:0] addr_high = 32'h00000fff,
    parameter logic [31:0] addr_low  = 32'h00000000,
    parameter bit          read_only = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_ram_bridge_if.slave wb,
    output logic [31:0]    ram_addr_o,
    output logic [31:0]    ram_data_o,
    output logic           ram_wren_o,
    input  logic [31:0]    ram_data_i
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
`ifdef WB_RAM_BYTE_SEL_EN
    localparam logic [2:0] S_RMW_RD   = 3'd3;
    localparam logic [2:0] S_RMW_WAIT = 3'd4;
`endif
    localparam logic [2:0] S_WR       = 3'd5;
    localparam logic [2:0] S_ACK      = 3'd6;
    localparam logic [2:0] S_ERR      = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wren_q, wren_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic        req;
    logic [31:0] word;
    logic [32:0] below_diff;
    logic [32:0] above_diff;
    logic        out_of_range;

    assign req  = wb.wb_cyc_i & wb.wb_stb_i;
    assign word = {2'b00, wb.wb_adr_i[31:2]};

    // Range test via borrow of 33-bit differences, so a zero addr_low needs no special case.
    assign below_diff   = {1'b0, word} - {1'b0, addr_low};
    assign above_diff   = {1'b0, addr_high} - {1'b0, word};
    assign out_of_range = below_diff[32] | above_diff[32];

`ifdef WB_RAM_BYTE_SEL_EN
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] merged;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged[8*gi +: 8] = sel_q[gi] ? dat_q[8*gi +: 8] : ram_data_i[8*gi +: 8];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q <= 4'h0;
            dat_q <= 32'h0;
        end else begin
            sel_q <= sel_d;
            dat_q <= dat_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wb.wb_adr_i[1:0], below_diff[31:0], above_diff[31:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_sel_i, below_diff[31:0], above_diff[31:0]};
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wren_d  = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
`ifdef WB_RAM_BYTE_SEL_EN
        sel_d   = sel_q;
        dat_d   = dat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (out_of_range || (read_only && wb.wb_we_i)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        addr_d = word;
                        if (!wb.wb_we_i) begin
                            state_d = S_RD;
`ifdef WB_RAM_BYTE_SEL_EN
                        end else if (wb.wb_sel_i == 4'h0) begin
                            state_d = S_WR;
                        end else if (wb.wb_sel_i != 4'hF) begin
                            state_d = S_RMW_RD;
                            sel_d   = wb.wb_sel_i;
                            dat_d   = wb.wb_dat_i;
`endif
                        end else begin
                            state_d = S_WR;
                            wdata_d = wb.wb_dat_i;
                            wren_d  = 1'b1;
                        end
                    end
                end
            end
            S_RD: state_d = wb.wb_cyc_i ? S_RD_WAIT : S_IDLE;
            S_RD_WAIT: begin
                if (wb.wb_cyc_i) begin
                    rdata_d = ram_data_i;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef WB_RAM_BYTE_SEL_EN
            S_RMW_RD: state_d = wb.wb_cyc_i ? S_RMW_WAIT : S_IDLE;
            S_RMW_WAIT: begin
                if (wb.wb_cyc_i) begin
                    wdata_d = merged;
                    wren_d  = 1'b1;
                    state_d = S_WR;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            // The write strobe has already gone out; only the ack depends on cyc.
            S_WR: begin
                if (wb.wb_cyc_i) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            wren_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wren_q  <= wren_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign ram_addr_o  = addr_q;
    assign ram_data_o  = wdata_q;
    assign ram_wren_o  = wren_q;
    assign wb.wb_dat_o = rdata_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
endmodule

// File: tb/tb_wb_ram_bridge.sv
// Directed bench for wb_ram_bridge with a read-first synchronous RAM model
// and a second, read-only instance.
module tb_wb_ram_bridge;
    logic        clk;
    logic        rst;
    logic [31:0] ram_addr, ram_wdata, ram_q;
    logic        ram_wren;
    logic [31:0] ro_addr, ro_wdata;
    logic        ro_wren;

    int checks = 0;
    int errors = 0;

    wb_ram_bridge_if bus ();
    wb_ram_bridge_if bus_ro ();

    wb_ram_bridge dut (
        .clk_i(clk), .rst_i(rst), .wb(bus),
        .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_wren_o(ram_wren),
        .ram_data_i(ram_q)
    );

    wb_ram_bridge #(.read_only(1'b1)) dut_ro (
        .clk_i(clk), .rst_i(rst), .wb(bus_ro),
        .ram_addr_o(ro_addr), .ram_data_o(ro_wdata), .ram_wren_o(ro_wren),
        .ram_data_i(32'h12345678)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: registered read, read-first write. Word i preloaded with A500_0000|i.
    logic [31:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= 32'hA5000000 | i;
    end
    always @(posedge clk) begin
        ram_q <= mem[ram_addr[11:0]];
        if (ram_wren) mem[ram_addr[11:0]] <= ram_wdata;
    end

    logic        req_we  [8];
    logic [31:0] req_adr [8];
    logic [3:0]  req_sel [8];
    logic [31:0] req_dat [8];
    int          req_n;

    logic [31:0] cap_ack, cap_err, cap_wren;
    logic [31:0] cap_rdat, cap_waddr, cap_wdata;
    int          cap_wren_cnt;

    task automatic bus_idle();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 32'h0; bus.wb_sel_i = 4'h0; bus.wb_dat_i = 32'h0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
        req_we[i] = we; req_adr[i] = adr; req_sel[i] = sel; req_dat[i] = dat;
    endtask

    task automatic present(input int i);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = req_we[i];
        bus.wb_adr_i = req_adr[i]; bus.wb_sel_i = req_sel[i]; bus.wb_dat_i = req_dat[i];
    endtask

    // Classic master: present the next request in the cycle after it saw a termination.
    task automatic run_reqs(input int ncyc);
        int   idx;
        logic prev_term;
        idx = 0; prev_term = 1'b0;
        cap_ack = '0; cap_err = '0; cap_wren = '0; cap_wren_cnt = 0;
        present(0);
        for (int j = 0; j < ncyc; j++) begin
            @(posedge clk); #1;
            cap_ack[j]  = bus.wb_ack_o;
            cap_err[j]  = bus.wb_err_o;
            cap_wren[j] = ram_wren;
            if (bus.wb_ack_o) cap_rdat = bus.wb_dat_o;
            if (ram_wren) begin
                cap_wren_cnt++; cap_waddr = ram_addr; cap_wdata = ram_wdata;
            end
            if (prev_term) begin
                idx++;
                if (idx < req_n) present(idx);
                else bus_idle();
            end
            prev_term = bus.wb_ack_o | bus.wb_err_o;
            if (prev_term)
                $display("txn we=%0b adr=%h sel=%h ack=%0b err=%0b rdat=%h cycle=%0d",
                         req_we[idx], req_adr[idx], req_sel[idx], bus.wb_ack_o, bus.wb_err_o,
                         bus.wb_dat_o, j);
        end
        bus_idle();
    endtask

    task automatic ro_txn(input logic we, input logic [31:0] adr, input int drop_at);
        cap_ack = '0; cap_err = '0; cap_wren = '0;
        bus_ro.wb_cyc_i = 1'b1; bus_ro.wb_stb_i = 1'b1; bus_ro.wb_we_i = we;
        bus_ro.wb_adr_i = adr; bus_ro.wb_sel_i = 4'hF; bus_ro.wb_dat_i = 32'hCAFEF00D;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            cap_ack[j]  = bus_ro.wb_ack_o;
            cap_err[j]  = bus_ro.wb_err_o;
            cap_wren[j] = ro_wren;
            if (bus_ro.wb_ack_o) cap_rdat = bus_ro.wb_dat_o;
            if (j == drop_at) begin bus_ro.wb_cyc_i = 1'b0; bus_ro.wb_stb_i = 1'b0; end
        end
        $display("txn ro we=%0b adr=%h ack=%h err=%h", we, adr, cap_ack, cap_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        bus_ro.wb_cyc_i = 1'b0; bus_ro.wb_stb_i = 1'b0; bus_ro.wb_we_i = 1'b0;
        bus_ro.wb_adr_i = 32'h0; bus_ro.wb_sel_i = 4'h0; bus_ro.wb_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", bus.wb_ack_o); end
        checks++; if (bus.wb_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.wb_err_o); end
        checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", bus.wb_dat_o); end
        checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", ram_addr); end
        checks++; if (ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", ram_wdata); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", ram_wren); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({bus.wb_ack_o, bus.wb_err_o, ram_wren} !== 3'b000) begin errors++; $display("FAIL idle_after_reset got %b exp 000", {bus.wb_ack_o, bus.wb_err_o, ram_wren}); end
        $display("txn reset done");
    endtask

    task automatic test_full_write_read();
        req_n = 1; set_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        run_reqs(6);
        checks++; if (cap_wren !== 32'h1) begin errors++; $display("FAIL wr_wren got %h exp %h", cap_wren, 32'h1); end
        checks++; if (cap_ack !== 32'h2) begin errors++; $display("FAIL wr_ack got %h exp %h", cap_ack, 32'h2); end
        checks++; if (cap_err !== 32'h0) begin errors++; $display("FAIL wr_err got %h exp 0", cap_err); end
        checks++; if (cap_waddr !== 32'h4) begin errors++; $display("FAIL wr_addr got %h exp 4", cap_waddr); end
        checks++; if (cap_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data got %h exp DEADBEEF", cap_wdata); end
        set_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
        run_reqs(6);
        checks++; if (cap_ack !== 32'h4) begin errors++; $display("FAIL rd_ack got %h exp %h", cap_ack, 32'h4); end
        checks++; if (cap_rdat !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp DEADBEEF", cap_rdat); end
        checks++; if (cap_wren !== 32'h0) begin errors++; $display("FAIL rd_wren got %h exp 0", cap_wren); end
        checks++; if (bus.wb_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dat_hold got %h exp DEADBEEF", bus.wb_dat_o); end
    endtask

    task automatic test_read_boundary();
        req_n = 1; set_req(0, 1'b0, 32'h20, 4'hF, 32'h0);
        run_reqs(5);
        checks++; if (cap_rdat !== 32'hA5000008) begin errors++; $display("FAIL rd_w8 got %h exp A5000008", cap_rdat); end
        set_req(0, 1'b0, 32'h3FFE, 4'hF, 32'h0);
        run_reqs(5);
        checks++; if (cap_ack !== 32'h4) begin errors++; $display("FAIL rd_high_ack got %h exp 4", cap_ack); end
        checks++; if (cap_rdat !== 32'hA5000FFF) begin errors++; $display("FAIL rd_high got %h exp A5000FFF", cap_rdat); end
    endtask

    task automatic test_error();
        req_n = 1; set_req(0, 1'b0, 32'h4000, 4'hF, 32'h0);
        run_reqs(5);
        checks++; if (cap_err !== 32'h1) begin errors++; $display("FAIL err_rd got %h exp 1", cap_err); end
        checks++; if (cap_ack !== 32'h0) begin errors++; $display("FAIL err_rd_ack got %h exp 0", cap_ack); end
        set_req(0, 1'b1, 32'h80000010, 4'hF, 32'h55555555);
        run_reqs(5);
        checks++; if (cap_err !== 32'h1) begin errors++; $display("FAIL err_wr got %h exp 1", cap_err); end
        checks++; if (cap_wren !== 32'h0) begin errors++; $display("FAIL err_wr_wren got %h exp 0", cap_wren); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL err_wr_mem got %h exp DEADBEEF", mem[4]); end
        req_n = 3;
        set_req(0, 1'b0, 32'h4000, 4'hF, 32'h0);
        set_req(1, 1'b0, 32'h4004, 4'hF, 32'h0);
        set_req(2, 1'b1, 32'hFFFFFFFC, 4'hF, 32'h0);
        run_reqs(8);
        checks++; if (cap_err !== 32'h15) begin errors++; $display("FAIL err_b2b got %h exp 15", cap_err); end
    endtask

    task automatic test_read_only();
        ro_txn(1'b1, 32'h0, 1);
        checks++; if (cap_err !== 32'h1) begin errors++; $display("FAIL ro_wr_err got %h exp 1", cap_err); end
        checks++; if (cap_ack !== 32'h0) begin errors++; $display("FAIL ro_wr_ack got %h exp 0", cap_ack); end
        checks++; if (cap_wren !== 32'h0) begin errors++; $display("FAIL ro_wr_wren got %h exp 0", cap_wren); end
        ro_txn(1'b0, 32'h8, 3);
        checks++; if (cap_ack !== 32'h4) begin errors++; $display("FAIL ro_rd_ack got %h exp 4", cap_ack); end
        checks++; if (cap_rdat !== 32'h12345678) begin errors++; $display("FAIL ro_rd_data got %h exp 12345678", cap_rdat); end
    endtask

    task automatic test_cyc_drop();
        logic [31:0] acks;
        acks = '0;
        req_n = 1; set_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
        present(0);
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            acks[j] = bus.wb_ack_o | bus.wb_err_o;
            if (j == 1) bus_idle();
        end
        $display("txn read dropped in RD_WAIT term=%h", acks);
        checks++; if (acks !== 32'h0) begin errors++; $display("FAIL drop_rd_term got %h exp 0", acks); end
        run_reqs(5);
        checks++; if (cap_ack !== 32'h4) begin errors++; $display("FAIL after_drop_ack got %h exp 4", cap_ack); end
        checks++; if (cap_rdat !== 32'hDEADBEEF) begin errors++; $display("FAIL after_drop_data got %h exp DEADBEEF", cap_rdat); end
        acks = '0;
        set_req(0, 1'b1, 32'h24, 4'hF, 32'h99990000);
        present(0);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            acks[j] = bus.wb_ack_o;
            if (j == 0) bus_idle();
        end
        $display("txn write dropped in WR ack=%h", acks);
        checks++; if (acks !== 32'h0) begin errors++; $display("FAIL drop_wr_ack got %h exp 0", acks); end
        checks++; if (mem[9] !== 32'h99990000) begin errors++; $display("FAIL drop_wr_mem got %h exp 99990000", mem[9]); end
    endtask

    task automatic test_reset_mid();
        req_n = 1;
`ifdef WB_RAM_BYTE_SEL_EN
        set_req(0, 1'b1, 32'h14, 4'b0010, 32'h0000FF00);
        present(0);
        repeat (2) @(posedge clk);
`else
        set_req(0, 1'b1, 32'h14, 4'hF, 32'h11112222);
        present(0);
        @(posedge clk);
`endif
        #3;
        rst = 1'b1;
        #1;
        checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr got %h exp 0", ram_addr); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL midrst_wren got %b exp 0", ram_wren); end
        checks++; if (ram_wdata !== 32'h0) begin errors++; $display("FAIL midrst_wdata got %h exp 0", ram_wdata); end
        checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL midrst_dat got %h exp 0", bus.wb_dat_o); end
        bus_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn reset mid-write released");
        @(posedge clk); #1;
        checks++; if (mem[5] !== 32'hA5000005) begin errors++; $display("FAIL midrst_mem got %h exp A5000005", mem[5]); end
        set_req(0, 1'b0, 32'h14, 4'hF, 32'h0);
        run_reqs(5);
        checks++; if (cap_ack !== 32'h4) begin errors++; $display("FAIL midrst_rd_ack got %h exp 4", cap_ack); end
        checks++; if (cap_rdat !== 32'hA5000005) begin errors++; $display("FAIL midrst_rd got %h exp A5000005", cap_rdat); end
    endtask

    task automatic test_back_to_back();
        req_n = 5;
        for (int i = 0; i < 5; i++) set_req(i, 1'b1, 32'h28 + 4 * i, 4'hF, 32'h0B0B0000 + i);
        run_reqs(17);
        checks++; if (cap_ack !== 32'h2492) begin errors++; $display("FAIL b2b_ack got %h exp 2492", cap_ack); end
        checks++; if (cap_wren !== 32'h1249) begin errors++; $display("FAIL b2b_wren got %h exp 1249", cap_wren); end
        checks++; if (cap_wren_cnt !== 5) begin errors++; $display("FAIL b2b_wren_cnt got %0d exp 5", cap_wren_cnt); end
        checks++; if (mem[10] !== 32'h0B0B0000) begin errors++; $display("FAIL b2b_mem10 got %h exp 0B0B0000", mem[10]); end
        checks++; if (mem[14] !== 32'h0B0B0004) begin errors++; $display("FAIL b2b_mem14 got %h exp 0B0B0004", mem[14]); end
        req_n = 2;
        set_req(0, 1'b0, 32'h2C, 4'hF, 32'h0);
        set_req(1, 1'b0, 32'h38, 4'hF, 32'h0);
        run_reqs(9);
        checks++; if (cap_ack !== 32'h44) begin errors++; $display("FAIL b2b_rd_ack got %h exp 44", cap_ack); end
        checks++; if (cap_rdat !== 32'h0B0B0004) begin errors++; $display("FAIL b2b_rd_data got %h exp 0B0B0004", cap_rdat); end
    endtask

    task automatic test_byte_sel();
        req_n = 1;
`ifdef WB_RAM_BYTE_SEL_EN
        set_req(0, 1'b1, 32'h10, 4'b0001, 32'h000000AA);
        run_reqs(7);
        checks++; if (cap_wren !== 32'h4) begin errors++; $display("FAIL rmw_wren got %h exp 4", cap_wren); end
        checks++; if (cap_ack !== 32'h8) begin errors++; $display("FAIL rmw_ack got %h exp 8", cap_ack); end
        checks++; if (cap_wdata !== 32'hDEADBEAA) begin errors++; $display("FAIL rmw_data got %h exp DEADBEAA", cap_wdata); end
        set_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
        run_reqs(5);
        checks++; if (cap_rdat !== 32'hDEADBEAA) begin errors++; $display("FAIL rmw_rd got %h exp DEADBEAA", cap_rdat); end
        set_req(0, 1'b1, 32'h10, 4'b1100, 32'h12345678);
        run_reqs(7);
        checks++; if (cap_wdata !== 32'h1234BEAA) begin errors++; $display("FAIL rmw2_data got %h exp 1234BEAA", cap_wdata); end
        set_req(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
        run_reqs(5);
        checks++; if (cap_ack !== 32'h2) begin errors++; $display("FAIL sel0_ack got %h exp 2", cap_ack); end
        checks++; if (cap_wren !== 32'h0) begin errors++; $display("FAIL sel0_wren got %h exp 0", cap_wren); end
        checks++; if (mem[4] !== 32'h1234BEAA) begin errors++; $display("FAIL sel0_mem got %h exp 1234BEAA", mem[4]); end
`else
        set_req(0, 1'b1, 32'h10, 4'b0001, 32'h000000AA);
        run_reqs(5);
        checks++; if (cap_wren !== 32'h1) begin errors++; $display("FAIL nosel_wren got %h exp 1", cap_wren); end
        checks++; if (cap_ack !== 32'h2) begin errors++; $display("FAIL nosel_ack got %h exp 2", cap_ack); end
        checks++; if (cap_wdata !== 32'h000000AA) begin errors++; $display("FAIL nosel_data got %h exp 000000AA", cap_wdata); end
        set_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
        run_reqs(5);
        checks++; if (cap_rdat !== 32'h000000AA) begin errors++; $display("FAIL nosel_rd got %h exp 000000AA", cap_rdat); end
`endif
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_read_boundary();
        test_error();
        test_read_only();
        test_cyc_drop();
        test_reset_mid();
        test_back_to_back();
        test_byte_sel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
